fpu_div_norm: RTL and testbench
===============================

Name: fpu_div_norm

Overview:
- Consumer end of the divider result interface (valid/ack, raw quotient fields) in the FPU.
- Accepts the raw 31-bit quotient, biased exponent, sign and destination from the divider.
- Normalises, rounds and packs the result into IEEE-754 single precision, then presents it to the register-file write-back arbiter on a valid/ready handshake.
- Single outstanding operation; back-pressures the divider by withholding div_ack.

Parameters:
- DEST_W, 5, width of destination register index.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- div_valid  in  1  divider result available
- div_mantissa  in  32  raw quotient; bit30 has weight 2^0, bit31 always 0
- div_exponent  in  8  biased exponent of the quotient before normalisation
- div_sign  in  1  result sign
- div_dest  in  DEST_W  destination register
- div_ack  out  1  one-cycle acknowledge; divider drops div_valid while high
- wb_valid  out  1  packed result valid
- wb_data  out  32  IEEE-754 result
- wb_dest  out  DEST_W  destination register
- wb_ready  in  1  arbiter accepts result
- norm_busy  out  1  state != IDLE

Behaviour:
- The design has one clock and a synchronous active-high reset.
- Reset values:
  - state=IDLE; div_ack=0; wb_valid=0; wb_data=0; wb_dest=0.
  - Reset mid-operation discards the captured operation with no write-back.
- div_ack timing:
  - div_ack is a registered output and must not depend combinationally on div_valid, because the divider gates its valid with ack.
  - div_ack is high only in the cycle after a capture.
- IDLE:
  - When div_valid=1, register mantissa[30:0], exponent, sign and dest at that edge.
  - Next state is NORM, with div_ack=1 in the following cycle.
  - div_valid is ignored in every state other than IDLE.
- NORM: one decision per cycle, in priority order.
  1. Mantissa==0: result is signed zero {sign,31'b0}; go to HOLD.
  2. m[30]==1: go to ROUND.
  3. exp==0 or exp==1: underflow; flush to signed zero; go to HOLD. Denormal outputs are not produced.
  4. Otherwise: m <= m<<1; exp <= exp-1; stay in NORM.
- ROUND:
  - Fraction is m[29:7], guard is m[6], sticky is |m[5:0].
  - Apply the rounding rule defined under Optional Feature.
  - A fraction carry-out sets fraction=0 and exp=exp+1.
  - If the final exp==255 (input 255, or carry from 254), the result is signed infinity {sign,8'hFF,23'b0}.
  - If the input exp==0 reaches ROUND, the result is signed zero.
  - Otherwise wb_data={sign,exp,fraction}. Go to HOLD.
- HOLD:
  - wb_valid=1; wb_data and wb_dest are held stable until wb_ready=1.
  - On wb_valid&&wb_ready the next state is IDLE, with wb_valid=0 next cycle.
  - A new div_valid can be captured from that IDLE cycle onward.
- Latency, counted from the first cycle div_valid=1 to the first wb_valid cycle:
  - 3 cycles when m[30]=1.
  - +1 cycle per normalisation shift.
  - Zero or underflow: 2 cycles plus shifts taken.
- Throughput: at most one operation in flight; norm_busy=1 from the cycle after capture until the return to IDLE.

Optional Feature:
- Macro: FPU_DIV_ROUND_EN.
- Defined: round-to-nearest-even. Increment the fraction when guard && (sticky || fraction[0]).
- Undefined: truncation. Guard and sticky are ignored; no carry, so overflow to infinity occurs only for an input exp of 255.
- Latency is identical in both builds.

Test Plan:
- 6.0/2.0:
  - Stimulus: mantissa=0x60000000, exp=128, sign=0, dest=3; wb_ready=1.
  - Response: div_ack pulses one cycle after capture; 3 cycles later wb_valid with wb_data=0x40400000, wb_dest=3.
- 1.0/1.5:
  - Stimulus: mantissa=0x2AAAAAAA, exp=127.
  - Response: one shift, latency 4. wb_data=0x3F2AAAAB with FPU_DIV_ROUND_EN; 0x3F2AAAAA without.
- Zero dividend:
  - Stimulus: mantissa=0, sign=1.
  - Response: wb_data=0x80000000 after 2 cycles.
- Overflow:
  - Stimulus: mantissa=0x7FFFFFFF, exp=254.
  - Response: 0x7F800000 with rounding; 0x7F7FFFFF without.
- Back-pressure:
  - Stimulus: hold wb_ready=0 for 5 cycles while the divider presents a second result.
  - Response: wb_data stable; no second div_ack. The second operation is captured only after the wb_ready handshake and completes with its own dest.
- Reset mid-NORM:
  - Stimulus: mantissa=0x00000100, reset asserted on the 4th NORM cycle.
  - Response: no wb_valid; state IDLE; div_ack=0; next operation processed normally.

Source files
------------

// File: rtl/fpu_div_norm.sv
// rtl/fpu_div_norm.sv - normalise, round and pack divider quotients into IEEE-754 single precision
// Define FPU_DIV_ROUND_EN for round-to-nearest-even; the default build truncates.
module fpu_div_norm #(
  parameter int DEST_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              div_valid,
  input  logic [31:0]       div_mantissa,
  input  logic [7:0]        div_exponent,
  input  logic              div_sign,
  input  logic [DEST_W-1:0] div_dest,
  output logic              div_ack,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [DEST_W-1:0] wb_dest,
  input  logic              wb_ready,
  output logic              norm_busy
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, HOLD} state_t;

  state_t            state;
  state_t            state_next;

  logic [31:0]       m_q;
  logic [7:0]        exp_q;
  logic              sign_q;
  logic [DEST_W-1:0] dest_q;

  logic              m_zero;
  logic              underflow;
  logic [22:0]       frac;
  logic              inc;
  logic [23:0]       frac_sum;
  logic [8:0]        exp_sum;
  logic [31:0]       round_result;

  // Bit 31 is never set by the divider; it still takes part in the zero test.
  assign m_zero    = (m_q == 32'd0);
  assign underflow = (exp_q <= 8'd1);
  assign frac      = m_q[29:7];

`ifdef FPU_DIV_ROUND_EN
  logic guard;
  logic sticky;
  assign guard  = m_q[6];
  assign sticky = |m_q[5:0];
  assign inc    = guard && (sticky || frac[0]);
`else
  assign inc    = 1'b0;
`endif

  assign frac_sum = {1'b0, frac} + {23'd0, inc};
  assign exp_sum  = {1'b0, exp_q} + {8'd0, frac_sum[23]};

  // A zero exponent that skipped normalisation still flushes; 255 or a carry past 254 saturates to infinity.
  always_comb begin
    round_result = {sign_q, exp_sum[7:0], frac_sum[22:0]};
    if (exp_q == 8'd0) begin
      round_result = {sign_q, 31'd0};
    end else if (exp_sum >= 9'd255) begin
      round_result = {sign_q, 8'hFF, 23'd0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (div_valid) begin
          state_next = NORM;
        end
      end
      NORM: begin
        if (m_zero) begin
          state_next = HOLD;
        end else if (m_q[30]) begin
          state_next = ROUND;
        end else if (underflow) begin
          state_next = HOLD;
        end
      end
      ROUND: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (wb_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_ack <= 1'b0;
      wb_data <= 32'd0;
      wb_dest <= '0;
      m_q     <= 32'd0;
      exp_q   <= 8'd0;
      sign_q  <= 1'b0;
      dest_q  <= '0;
    end else begin
      div_ack <= (state == IDLE) && div_valid;
      case (state)
        IDLE: begin
          if (div_valid) begin
            m_q    <= {1'b0, div_mantissa[30:0]};
            exp_q  <= div_exponent;
            sign_q <= div_sign;
            dest_q <= div_dest;
          end
        end
        NORM: begin
          if (m_zero || (!m_q[30] && underflow)) begin
            wb_data <= {sign_q, 31'd0};
            wb_dest <= dest_q;
          end else if (!m_q[30]) begin
            m_q   <= {m_q[30:0], 1'b0};
            exp_q <= exp_q - 8'd1;
          end
        end
        ROUND: begin
          wb_data <= round_result;
          wb_dest <= dest_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign wb_valid  = (state == HOLD);
  assign norm_busy = (state != IDLE);

endmodule

// File: tb/tb_fpu_div_norm.sv
// tb/tb_fpu_div_norm.sv - directed bench for fpu_div_norm
// Expected values follow FPU_DIV_ROUND_EN when it is defined for the build.
module tb_fpu_div_norm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        div_valid = 1'b0;
  logic [31:0] div_mantissa = 32'd0;
  logic [7:0]  div_exponent = 8'd0;
  logic        div_sign = 1'b0;
  logic [4:0]  div_dest = 5'd0;
  logic        div_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_ready = 1'b1;
  logic        norm_busy;

  int checks = 0;
  int errors = 0;

`ifdef FPU_DIV_ROUND_EN
  localparam logic [31:0] EXP_ONE_OVER_1P5 = 32'h3F2AAAAB;
  localparam logic [31:0] EXP_OVERFLOW     = 32'h7F800000;
`else
  localparam logic [31:0] EXP_ONE_OVER_1P5 = 32'h3F2AAAAA;
  localparam logic [31:0] EXP_OVERFLOW     = 32'h7F7FFFFF;
`endif

  fpu_div_norm #(.DEST_W(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .div_valid    (div_valid),
    .div_mantissa (div_mantissa),
    .div_exponent (div_exponent),
    .div_sign     (div_sign),
    .div_dest     (div_dest),
    .div_ack      (div_ack),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_dest      (wb_dest),
    .wb_ready     (wb_ready),
    .norm_busy    (norm_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic present(input logic [31:0] m, input logic [7:0] e, input logic s, input logic [4:0] d);
    div_mantissa = m;
    div_exponent = e;
    div_sign     = s;
    div_dest     = d;
    div_valid    = 1'b1;
  endtask

  // Present one operation with wb_ready high and check ack, latency, data and dest.
  task automatic run_op(input string tag, input logic [31:0] m, input logic [7:0] e, input logic s,
                        input logic [4:0] d, input logic [31:0] expd, input int explat);
    int n;
    @(negedge clock);
    present(m, e, s, d);
    @(negedge clock);
    n = 1;
    check({tag, "_ack"}, {31'd0, div_ack}, 32'd1);
    check({tag, "_busy"}, {31'd0, norm_busy}, 32'd1);
    div_valid = 1'b0;
    while (wb_valid !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_valid"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_latency"}, n, explat);
    check({tag, "_data"}, wb_data, expd);
    check({tag, "_dest"}, {27'd0, wb_dest}, {27'd0, d});
    check({tag, "_ack_low"}, {31'd0, div_ack}, 32'd0);
    @(negedge clock);
    check({tag, "_released"}, {30'd0, wb_valid, norm_busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic seen;

    // reset state
    repeat (2) @(negedge clock);
    check("rst_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_ack", {31'd0, div_ack}, 32'd0);
    check("rst_busy", {31'd0, norm_busy}, 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_dest", {27'd0, wb_dest}, 32'd0);
    reset = 1'b0;

    run_op("six_div_two", 32'h60000000, 8'd128, 1'b0, 5'd3, 32'h40400000, 3);
    run_op("one_div_1p5", 32'h2AAAAAAA, 8'd127, 1'b0, 5'd4, EXP_ONE_OVER_1P5, 4);
    run_op("zero_dividend", 32'h00000000, 8'd100, 1'b1, 5'd5, 32'h80000000, 2);
    run_op("overflow", 32'h7FFFFFFF, 8'd254, 1'b0, 5'd6, EXP_OVERFLOW, 3);
    run_op("underflow", 32'h10000000, 8'd2, 1'b1, 5'd7, 32'h80000000, 3);
    run_op("exp_zero_round", 32'h40000000, 8'd0, 1'b1, 5'd8, 32'h80000000, 3);
    run_op("exp_255", 32'h40000000, 8'd255, 1'b0, 5'd9, 32'h7F800000, 3);

    // back-pressure with a second result waiting
    wb_ready = 1'b0;
    @(negedge clock);
    present(32'h60000000, 8'd128, 1'b0, 5'd3);
    @(negedge clock);
    n = 1;
    div_valid = 1'b0;
    while (wb_valid !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    check("bp_first_valid", {31'd0, wb_valid}, 32'd1);
    check("bp_first_latency", n, 3);
    present(32'h40000000, 8'd127, 1'b1, 5'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_hold_valid", {31'd0, wb_valid}, 32'd1);
      check("bp_hold_data", wb_data, 32'h40400000);
      check("bp_hold_dest", {27'd0, wb_dest}, 32'd3);
      check("bp_no_ack", {31'd0, div_ack}, 32'd0);
    end
    wb_ready = 1'b1;
    @(negedge clock);
    check("bp_idle_valid", {31'd0, wb_valid}, 32'd0);
    check("bp_idle_ack", {31'd0, div_ack}, 32'd0);
    @(negedge clock);
    check("bp_second_ack", {31'd0, div_ack}, 32'd1);
    div_valid = 1'b0;
    n = 1;
    while (wb_valid !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    check("bp_second_valid", {31'd0, wb_valid}, 32'd1);
    check("bp_second_latency", n, 3);
    check("bp_second_data", wb_data, 32'hBF800000);
    check("bp_second_dest", {27'd0, wb_dest}, 32'd12);
    @(negedge clock);

    // reset in the fourth NORM cycle
    @(negedge clock);
    present(32'h00000100, 8'd127, 1'b0, 5'd10);
    @(negedge clock);
    div_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_busy_before", {31'd0, norm_busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_busy", {31'd0, norm_busy}, 32'd0);
    check("mid_ack", {31'd0, div_ack}, 32'd0);
    check("mid_valid", {31'd0, wb_valid}, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (wb_valid === 1'b1) seen = 1'b1;
    end
    check("mid_no_writeback", {31'd0, seen}, 32'd0);
    run_op("after_reset", 32'h60000000, 8'd128, 1'b0, 5'd11, 32'h40400000, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
